// File: rtl/harvard_mem_pkg.sv
// Shared constants and port-FSM state encoding for the
// split instruction/data memory.
package harvard_mem_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_ADDRSIZE = 12;
   localparam int CNT_W        = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   function automatic logic addr_ok(
      input logic [31:0] addr,
      input int unsigned words
   );
      return addr < words;
   endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// Per-port request sequencer: IDLE -> (WAIT x N) -> RESP -> IDLE.
// valid and busy are registered copies of the response/non-idle state.
module mem_port_fsm
   import harvard_mem_pkg::*;
#(
   parameter int WAIT_CNT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   output logic accept,
   output logic resp,
   output logic valid,
   output logic busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_CNT > 0) ? CNT_W'(WAIT_CNT - 1) : '0;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;

   assign accept = (state == ST_IDLE) && req;
   assign resp   = (state == ST_RESP);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (req) begin
               state_nx = (WAIT_CNT > 0) ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               state_nx = ST_RESP;
            end
         end
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // cnt holds the wait cycles still to run after the current one
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         valid <= resp;
         busy  <= (state_nx != ST_IDLE);
         if (accept) begin
            cnt <= CNT_LOAD;
         end else if (state == ST_WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/harvard_mem.sv
// Dual-port Harvard memory: independent instruction and data ports
// with configurable wait states sharing one word array.
module harvard_mem
   import harvard_mem_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ADDRSIZE  = DEF_ADDRSIZE,
   parameter int MEM_WORDS = 4096,
   parameter int I_WAIT    = 0,
   parameter int D_WAIT    = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                INS_REQ,
   input  logic [ADDRSIZE-1:0] INS_ADDR,
   output logic [WIDTH-1:0]    INS_MEM,
   output logic                INS_VALID,
   output logic                INS_BUSY,
   output logic                INS_ERR,
   input  logic                MEM_REQ,
   input  logic                MEM_CTRL,
   input  logic [ADDRSIZE-1:0] MEM_ADDR,
   input  logic [WIDTH-1:0]    MEM_OUT,
   output logic [WIDTH-1:0]    MEM_IN,
   output logic                MEM_VALID,
   output logic                MEM_BUSY,
   output logic                MEM_ERR
);

   localparam int DEPTH = 1 << ADDRSIZE;

   logic [WIDTH-1:0]    mem [DEPTH];

   logic                i_accept;
   logic                i_resp;
   logic                d_accept;
   logic                d_resp;
   logic [ADDRSIZE-1:0] i_addr_q;
   logic [ADDRSIZE-1:0] d_addr_q;
   logic                d_we_q;
   logic [WIDTH-1:0]    d_wdata_q;
   logic                i_ok;
   logic                d_ok;

   mem_port_fsm #(
      .WAIT_CNT (I_WAIT)
   ) u_ins_fsm (
      .clk    (clk),
      .rst    (rst),
      .req    (INS_REQ),
      .accept (i_accept),
      .resp   (i_resp),
      .valid  (INS_VALID),
      .busy   (INS_BUSY)
   );

   mem_port_fsm #(
      .WAIT_CNT (D_WAIT)
   ) u_dat_fsm (
      .clk    (clk),
      .rst    (rst),
      .req    (MEM_REQ),
      .accept (d_accept),
      .resp   (d_resp),
      .valid  (MEM_VALID),
      .busy   (MEM_BUSY)
   );

   assign i_ok = addr_ok(32'(i_addr_q), MEM_WORDS);
   assign d_ok = addr_ok(32'(d_addr_q), MEM_WORDS);

   always_ff @(posedge clk) begin
      if (rst) begin
         i_addr_q  <= '0;
         d_addr_q  <= '0;
         d_we_q    <= 1'b0;
         d_wdata_q <= '0;
      end else begin
         if (i_accept) begin
            i_addr_q <= INS_ADDR;
         end
         if (d_accept) begin
            d_addr_q  <= MEM_ADDR;
            d_we_q    <= MEM_CTRL;
            d_wdata_q <= MEM_OUT;
         end
      end
   end

   // Reads sample the array before this edge's write lands,
   // giving read-before-write on a same-edge collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         INS_MEM <= '0;
         INS_ERR <= 1'b0;
         MEM_IN  <= '0;
         MEM_ERR <= 1'b0;
      end else begin
         INS_ERR <= i_resp && !i_ok;
         MEM_ERR <= d_resp && !d_ok;
         if (i_resp) begin
            INS_MEM <= i_ok ? mem[i_addr_q] : '0;
         end
         if (d_resp && !d_we_q) begin
            MEM_IN <= d_ok ? mem[d_addr_q] : '0;
         end
      end
   end

   // No reset on the array: contents survive rst
   always_ff @(posedge clk) begin
      if (!rst && d_resp && d_we_q && d_ok) begin
         mem[d_addr_q] <= d_wdata_q;
      end
   end

endmodule

// File: tb/tb_harvard_mem.sv
// Self-checking bench for harvard_mem: two instances with different
// wait counts, checked against a word-array model of the memory.
module tb_harvard_mem;

   localparam int AW   = 6;
   localparam int NW   = 16;
   localparam int A_IW = 0;
   localparam int A_DW = 1;
   localparam int B_IW = 2;
   localparam int B_DW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a;
   logic          ins_req;
   logic [AW-1:0] ins_addr;
   logic [31:0]   ins_mem;
   logic          ins_valid;
   logic          ins_busy;
   logic          ins_err;
   logic          mem_req;
   logic          mem_ctrl;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_out;
   logic [31:0]   mem_in;
   logic          mem_valid;
   logic          mem_busy;
   logic          mem_err;

   logic          rst_b;
   logic          b_ins_req;
   logic [AW-1:0] b_ins_addr;
   logic [31:0]   b_ins_mem;
   logic          b_ins_valid;
   logic          b_ins_busy;
   logic          b_ins_err;
   logic          b_mem_req;
   logic          b_mem_ctrl;
   logic [AW-1:0] b_mem_addr;
   logic [31:0]   b_mem_out;
   logic [31:0]   b_mem_in;
   logic          b_mem_valid;
   logic          b_mem_busy;
   logic          b_mem_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [NW];
   logic [31:0] last_rd;
   logic [31:0] last_ins;

   harvard_mem #(
      .WIDTH     (32),
      .ADDRSIZE  (AW),
      .MEM_WORDS (NW),
      .I_WAIT    (A_IW),
      .D_WAIT    (A_DW)
   ) u_dut_a (
      .clk       (clk),
      .rst       (rst_a),
      .INS_REQ   (ins_req),
      .INS_ADDR  (ins_addr),
      .INS_MEM   (ins_mem),
      .INS_VALID (ins_valid),
      .INS_BUSY  (ins_busy),
      .INS_ERR   (ins_err),
      .MEM_REQ   (mem_req),
      .MEM_CTRL  (mem_ctrl),
      .MEM_ADDR  (mem_addr),
      .MEM_OUT   (mem_out),
      .MEM_IN    (mem_in),
      .MEM_VALID (mem_valid),
      .MEM_BUSY  (mem_busy),
      .MEM_ERR   (mem_err)
   );

   harvard_mem #(
      .WIDTH     (32),
      .ADDRSIZE  (AW),
      .MEM_WORDS (NW),
      .I_WAIT    (B_IW),
      .D_WAIT    (B_DW)
   ) u_dut_b (
      .clk       (clk),
      .rst       (rst_b),
      .INS_REQ   (b_ins_req),
      .INS_ADDR  (b_ins_addr),
      .INS_MEM   (b_ins_mem),
      .INS_VALID (b_ins_valid),
      .INS_BUSY  (b_ins_busy),
      .INS_ERR   (b_ins_err),
      .MEM_REQ   (b_mem_req),
      .MEM_CTRL  (b_mem_ctrl),
      .MEM_ADDR  (b_mem_addr),
      .MEM_OUT   (b_mem_out),
      .MEM_IN    (b_mem_in),
      .MEM_VALID (b_mem_valid),
      .MEM_BUSY  (b_mem_busy),
      .MEM_ERR   (b_mem_err)
   );

   task automatic data_op(
      input logic          we,
      input logic [AW-1:0] a,
      input logic [31:0]   wd,
      input string         tag
   );
      int          lat;
      logic        exp_err;
      logic [31:0] exp_rd;
      exp_err = (int'(a) >= NW);
      if (!we) last_rd = exp_err ? 32'd0 : ref_mem[a[3:0]];
      exp_rd = last_rd;
      if (we && !exp_err) ref_mem[a[3:0]] = wd;
      mem_req  = 1'b1;
      mem_ctrl = we;
      mem_addr = a;
      mem_out  = wd;
      @(posedge clk); #1;
      mem_req  = 1'b0;
      mem_ctrl = 1'b0;
      mem_addr = AW'($urandom);
      mem_out  = $urandom;
      checks++;
      if (mem_busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy got %b want 1", tag, mem_busy);
      end
      lat = 0;
      while (mem_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != 1 + A_DW) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d", tag, lat, 1 + A_DW);
      end
      checks++;
      if (mem_in !== exp_rd || mem_err !== exp_err) begin
         errors++;
         $display("FAIL %s data got %h/%b want %h/%b",
                  tag, mem_in, mem_err, exp_rd, exp_err);
      end
      @(posedge clk); #1;
      checks++;
      if (mem_valid !== 1'b0 || mem_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s pulse got v=%b b=%b want 0/0",
                  tag, mem_valid, mem_busy);
      end
   endtask

   task automatic ins_op(input logic [AW-1:0] a, input string tag);
      int   lat;
      logic exp_err;
      exp_err  = (int'(a) >= NW);
      last_ins = exp_err ? 32'd0 : ref_mem[a[3:0]];
      ins_req  = 1'b1;
      ins_addr = a;
      @(posedge clk); #1;
      ins_req  = 1'b0;
      ins_addr = AW'($urandom);
      lat = 0;
      while (ins_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != 1 + A_IW) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d", tag, lat, 1 + A_IW);
      end
      checks++;
      if (ins_mem !== last_ins || ins_err !== exp_err) begin
         errors++;
         $display("FAIL %s data got %h/%b want %h/%b",
                  tag, ins_mem, ins_err, last_ins, exp_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic b_data_op(
      input  logic          we,
      input  logic [AW-1:0] a,
      input  logic [31:0]   wd,
      output logic [31:0]   rd,
      output int            lat
   );
      b_mem_req  = 1'b1;
      b_mem_ctrl = we;
      b_mem_addr = a;
      b_mem_out  = wd;
      @(posedge clk); #1;
      b_mem_req  = 1'b0;
      b_mem_ctrl = 1'b0;
      lat = 0;
      while (b_mem_valid !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = b_mem_in;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ins_valid, ins_busy, ins_err, mem_valid, mem_busy, mem_err}
          !== 6'b0 || ins_mem !== 32'd0 || mem_in !== 32'd0) begin
         errors++;
         $display("FAIL reset_a got %b%b%b%b%b%b %h %h want zeros",
                  ins_valid, ins_busy, ins_err, mem_valid, mem_busy,
                  mem_err, ins_mem, mem_in);
      end
      checks++;
      if ({b_ins_valid, b_ins_busy, b_ins_err,
           b_mem_valid, b_mem_busy, b_mem_err} !== 6'b0 ||
          b_ins_mem !== 32'd0 || b_mem_in !== 32'd0) begin
         errors++;
         $display("FAIL reset_b got %h %h want zeros", b_ins_mem, b_mem_in);
      end
      rst_a    = 1'b0;
      rst_b    = 1'b0;
      last_rd  = 32'd0;
      last_ins = 32'd0;
      @(posedge clk); #1;
   endtask

   task automatic test_preload();
      for (int i = 0; i < NW; i++) begin
         data_op(1'b1, AW'(i), $urandom, "preload");
      end
   endtask

   task automatic test_write_read();
      data_op(1'b1, 6'd5, 32'h0000_00AA, "wr5");
      data_op(1'b0, 6'd5, 32'd0, "rd5");
   endtask

   task automatic test_ins_stream();
      ins_req  = 1'b1;
      ins_addr = '0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k < 2) ins_addr = AW'(k + 1);
         else ins_req = 1'b0;
         checks++;
         if (ins_valid !== 1'b0 || ins_busy !== 1'b1) begin
            errors++;
            $display("FAIL stream_gap%0d got v=%b b=%b want 0/1",
                     k, ins_valid, ins_busy);
         end
         @(posedge clk); #1;
         checks++;
         if (ins_valid !== 1'b1 || ins_mem !== ref_mem[k]) begin
            errors++;
            $display("FAIL stream%0d got v=%b %h want 1 %h",
                     k, ins_valid, ins_mem, ref_mem[k]);
         end
      end
      last_ins = ref_mem[2];
      @(posedge clk); #1;
      checks++;
      if (ins_valid !== 1'b0 || ins_busy !== 1'b0) begin
         errors++;
         $display("FAIL stream_end got v=%b b=%b want 0/0",
                  ins_valid, ins_busy);
      end
   endtask

   task automatic test_collision();
      data_op(1'b1, 6'd7, 32'h11, "col_old");
      mem_req  = 1'b1;
      mem_ctrl = 1'b1;
      mem_addr = 6'd7;
      mem_out  = 32'h55;
      @(posedge clk); #1;
      mem_req  = 1'b0;
      mem_ctrl = 1'b0;
      ins_req  = 1'b1;
      ins_addr = 6'd7;
      @(posedge clk); #1;
      ins_req  = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ins_valid !== 1'b1 || mem_valid !== 1'b1 ||
          ins_mem !== 32'h11 || mem_in !== last_rd) begin
         errors++;
         $display("FAIL collision got iv=%b dv=%b %h %h want 1 1 11 %h",
                  ins_valid, mem_valid, ins_mem, mem_in, last_rd);
      end
      ref_mem[7] = 32'h55;
      @(posedge clk); #1;
      ins_op(6'd7, "col_new");
   endtask

   task automatic test_out_of_range();
      data_op(1'b0, 6'd20, 32'd0, "oor_rd");
      data_op(1'b1, 6'd20, 32'hFF, "oor_wr");
      data_op(1'b0, 6'd4, 32'd0, "oor_alias");
      ins_op(6'd20, "oor_if");
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] seq [3];
      logic [31:0]   exp;
      logic          exp_err;
      for (int i = 0; i < 3; i++) seq[i] = AW'($urandom_range(0, 23));
      mem_req  = 1'b1;
      mem_ctrl = 1'b0;
      mem_addr = seq[0];
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k < 2) mem_addr = seq[k + 1];
         else mem_req = 1'b0;
         for (int j = 1; j <= 1 + A_DW; j++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_valid !== (j == 1 + A_DW)) begin
               errors++;
               $display("FAIL b2b%0d cyc%0d valid got %b", k, j, mem_valid);
            end
         end
         exp_err = (int'(seq[k]) >= NW);
         exp     = exp_err ? 32'd0 : ref_mem[seq[k][3:0]];
         checks++;
         if (mem_in !== exp || mem_err !== exp_err) begin
            errors++;
            $display("FAIL b2b%0d data got %h/%b want %h/%b",
                     k, mem_in, mem_err, exp, exp_err);
         end
         last_rd = exp;
      end
      @(posedge clk); #1;
      checks++;
      if (mem_valid !== 1'b0 || mem_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end got v=%b b=%b want 0/0", mem_valid, mem_busy);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int n = 0; n < 60; n++) begin
         a = AW'($urandom_range(0, 23));
         case ($urandom_range(0, 2))
            0:       data_op(1'b1, a, $urandom, "rnd_wr");
            1:       data_op(1'b0, a, 32'd0, "rnd_rd");
            default: ins_op(a, "rnd_if");
         endcase
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd;
      int          lat;
      b_data_op(1'b1, 6'd3, 32'h33, rd, lat);
      b_data_op(1'b0, 6'd3, 32'd0, rd, lat);
      checks++;
      if (rd !== 32'h33 || lat != 1 + B_DW) begin
         errors++;
         $display("FAIL b_pre got %h lat %0d want 33 lat %0d",
                  rd, lat, 1 + B_DW);
      end
      b_ins_req  = 1'b1;
      b_ins_addr = 6'd3;
      @(posedge clk); #1;
      b_ins_req  = 1'b0;
      lat = 0;
      while (b_ins_valid !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (b_ins_mem !== 32'h33 || lat != 1 + B_IW) begin
         errors++;
         $display("FAIL b_fetch got %h lat %0d want 33 lat %0d",
                  b_ins_mem, lat, 1 + B_IW);
      end
      @(posedge clk); #1;
      b_mem_req  = 1'b1;
      b_mem_ctrl = 1'b1;
      b_mem_addr = 6'd3;
      b_mem_out  = 32'h99;
      @(posedge clk); #1;
      b_mem_req  = 1'b0;
      b_mem_ctrl = 1'b0;
      @(posedge clk); #1;
      rst_b      = 1'b1;
      b_mem_req  = 1'b1;
      b_mem_addr = 6'd3;
      @(posedge clk); #1;
      checks++;
      if ({b_ins_valid, b_ins_busy, b_ins_err,
           b_mem_valid, b_mem_busy, b_mem_err} !== 6'b0 ||
          b_ins_mem !== 32'd0 || b_mem_in !== 32'd0) begin
         errors++;
         $display("FAIL b_abort_rst got %h %h busy %b want zeros",
                  b_ins_mem, b_mem_in, b_mem_busy);
      end
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (b_mem_valid !== 1'b0 || b_mem_busy !== 1'b0) begin
            errors++;
            $display("FAIL b_hold got v=%b b=%b want 0/0",
                     b_mem_valid, b_mem_busy);
         end
      end
      rst_b = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (b_mem_busy !== 1'b1) begin
         errors++;
         $display("FAIL b_first_accept busy got %b want 1", b_mem_busy);
      end
      b_mem_req = 1'b0;
      lat = 0;
      while (b_mem_valid !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != 1 + B_DW || b_mem_in !== 32'h33 || b_mem_err !== 1'b0) begin
         errors++;
         $display("FAIL b_retain got %h/%b lat %0d want 33/0 lat %0d",
                  b_mem_in, b_mem_err, lat, 1 + B_DW);
      end
   endtask

   initial begin
      rst_a      = 1'b1;
      rst_b      = 1'b1;
      ins_req    = 1'b0;
      ins_addr   = '0;
      mem_req    = 1'b0;
      mem_ctrl   = 1'b0;
      mem_addr   = '0;
      mem_out    = '0;
      b_ins_req  = 1'b0;
      b_ins_addr = '0;
      b_mem_req  = 1'b0;
      b_mem_ctrl = 1'b0;
      b_mem_addr = '0;
      b_mem_out  = '0;
      last_rd    = '0;
      last_ins   = '0;
      test_reset();
      test_preload();
      test_write_read();
      test_ins_stream();
      test_collision();
      test_out_of_range();
      test_back_to_back();
      test_random();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
